// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   Memory-mapped PS/2 keyboard receiver. Raw PS/2 clock/data lines are
//   synchronised, falling edges of the PS/2 clock advance a frame state
//   machine (start, 8 data bits LSB first, odd parity, stop), and good
//   bytes are queued in a scancode FIFO the CPU drains through the DATA
//   register. Sticky error flags record parity, framing and overrun
//   events; an optional level interrupt flags a non-empty FIFO.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   cs, read, write     bus select and strobes
//   reg_offset[1:0]     0 STATUS, 1 DATA, 2 CONTROL, 3 reserved
//   data_in[31:0]       write data, only [31:24] meaningful
//   data_out[31:0]      combinational read data, 0 when cs is low
//   ps2_clock, ps2_data raw asynchronous PS/2 lines
//   irq                 registered level interrupt
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 12000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  reg_offset,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        ps2_clock,
  input  logic        ps2_data,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  // ---------------------------------------------------------------
  // Input synchronisers. Reset to 1 because an idle PS/2 bus is high,
  // so leaving reset never fabricates a falling edge.
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clkSync_q;
  logic [SYNC_STAGES-1:0] dataSync_q;
  logic                   prevClk_q;
  logic                   syncClk;
  logic                   sampledBit;
  logic                   fallPulse;

  always_ff @(posedge clock) begin
    if (reset) begin
      clkSync_q  <= '1;
      dataSync_q <= '1;
      prevClk_q  <= 1'b1;
    end else begin
      clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], ps2_clock};
      dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], ps2_data};
      prevClk_q  <= clkSync_q[SYNC_STAGES-1];
    end
  end

  assign syncClk    = clkSync_q[SYNC_STAGES-1];
  assign sampledBit = dataSync_q[SYNC_STAGES-1];
  assign fallPulse  = prevClk_q & ~syncClk;

  // ---------------------------------------------------------------
  // Bus decode. A DATA read pops only on the rising edge of the
  // decoded strobe so a stretched read consumes exactly one byte.
  // ---------------------------------------------------------------
  logic wrStatus;
  logic wrControl;
  logic flush;
  logic popReq;
  logic popReq_q;
  logic popEdge;

  assign wrStatus  = cs & write & (reg_offset == 2'd0);
  assign wrControl = cs & write & (reg_offset == 2'd2);
  assign flush     = wrControl & data_in[30];
  assign popReq    = cs & read & (reg_offset == 2'd1);
  assign popEdge   = popReq & ~popReq_q;

  always_ff @(posedge clock) begin
    if (reset) popReq_q <= 1'b0;
    else       popReq_q <= popReq;
  end

  // ---------------------------------------------------------------
  // Frame state machine: state register.
  // ---------------------------------------------------------------
  state_e state_q;
  state_e state_d;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------
  // Frame datapath and timeout counter. The counter idles at 0 in IDLE
  // and restarts on every falling edge, so it measures the silence
  // since the last edge of a frame in progress.
  // ---------------------------------------------------------------
  logic [7:0]    shift_q;
  logic [2:0]    bitCnt_q;
  logic          parity_q;
  logic [TW-1:0] toCnt_q;
  logic          timeoutHit;

  assign timeoutHit = (state_q != IDLE) & ~fallPulse &
                      (toCnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q  <= '0;
      bitCnt_q <= '0;
      parity_q <= 1'b0;
    end else if (fallPulse) begin
      case (state_q)
        IDLE:    bitCnt_q <= '0;
        DATA: begin
          shift_q  <= {sampledBit, shift_q[7:1]};
          bitCnt_q <= bitCnt_q + 3'd1;
        end
        PARITY:  parity_q <= sampledBit;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      toCnt_q <= '0;
    end else if (flush || (state_q == IDLE) || fallPulse || timeoutHit) begin
      toCnt_q <= '0;
    end else begin
      toCnt_q <= toCnt_q + TW'(1);
    end
  end

  // ---------------------------------------------------------------
  // Frame state machine: next-state logic. Flush beats everything,
  // then falling edges, then the timeout abort.
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else if (fallPulse) begin
      case (state_q)
        IDLE:    if (!sampledBit) state_d = DATA;
        DATA:    if (bitCnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (timeoutHit) begin
      state_d = IDLE;
    end
  end

  // ---------------------------------------------------------------
  // Frame state machine: outputs. The stop bit is checked as it is
  // sampled; parity is odd over the data byte plus the parity bit.
  // ---------------------------------------------------------------
  logic stopEdge;
  logic stopBad;
  logic parityBad;
  logic pushReq;
  logic framingSet;
  logic paritySet;

  always_comb begin
    stopEdge   = fallPulse & (state_q == STOP);
    stopBad    = ~sampledBit;
    parityBad  = ~(^{shift_q, parity_q});
    pushReq    = stopEdge & ~stopBad & ~parityBad;
    framingSet = (stopEdge & stopBad) | timeoutHit;
    paritySet  = stopEdge & parityBad;
  end

  // ---------------------------------------------------------------
  // Scancode FIFO. A pop in the same cycle frees a slot, so a push
  // into a full FIFO still succeeds when paired with a pop.
  // ---------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [CW-1:0] count_q;
  logic          full;
  logic          notEmpty;
  logic          doPop;
  logic          doPush;
  logic          overrunSet;
  logic [7:0]    head;

  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign notEmpty   = (count_q != '0);
  assign doPop      = popEdge & notEmpty;
  assign doPush     = pushReq & ~flush & (~full | doPop);
  assign overrunSet = pushReq & ~flush & full & ~doPop;
  assign head       = mem_q[rdPtr_q];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (doPush) mem_q[wrPtr_q] <= shift_q;
  end

  // ---------------------------------------------------------------
  // Sticky flags, write-1-to-clear. A set in the same cycle as a clear
  // wins so no event is ever silently lost.
  // ---------------------------------------------------------------
  logic parityErr_q,  parityErr_d;
  logic framingErr_q, framingErr_d;
  logic overrun_q,    overrun_d;

  always_comb begin
    parityErr_d  = (parityErr_q  & ~(wrStatus & data_in[30])) | paritySet;
    framingErr_d = (framingErr_q & ~(wrStatus & data_in[29])) | framingSet;
    overrun_d    = (overrun_q    & ~(wrStatus & data_in[28])) | overrunSet;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      parityErr_q  <= 1'b0;
      framingErr_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      parityErr_q  <= parityErr_d;
      framingErr_q <= framingErr_d;
      overrun_q    <= overrun_d;
    end
  end

  // ---------------------------------------------------------------
  // Interrupt enable and registered interrupt output.
  // ---------------------------------------------------------------
  logic irqEnable_q;
  logic irq_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      irqEnable_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (wrControl) irqEnable_q <= data_in[31];
      irq_q <= irqEnable_q & notEmpty;
    end
  end

  assign irq = irq_q;

  // ---------------------------------------------------------------
  // Read mux.
  // ---------------------------------------------------------------
  logic [31:0] statusWord;

  assign statusWord = {notEmpty, parityErr_q, framingErr_q, overrun_q, full,
                       3'b000, 8'(count_q), 16'h0000};

  always_comb begin
    data_out = '0;
    if (cs) begin
      case (reg_offset)
        2'd0:    data_out = statusWord;
        2'd1:    data_out = notEmpty ? {head, 24'h000000} : 32'h0;
        2'd2:    data_out = {irqEnable_q, 31'b0};
        default: data_out = '0;
      endcase
    end
  end

  // Low write-data bits carry no register fields.
  logic unusedDataBits;
  assign unusedDataBits = ^data_in[27:0];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int TMO   = 300;

  logic        clock = 1'b0;
  logic        reset;
  logic        cs, read, write;
  logic [1:0]  reg_offset;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ps2_clock, ps2_data;
  logic        irq;

  int total = 0;
  int bad   = 0;

  // Reference model state
  byte unsigned mQ[$];
  bit mPar, mFrm, mOvr, mIrqEn;

  always #5 clock = ~clock;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .cs(cs), .read(read), .write(write),
    .reg_offset(reg_offset), .data_in(data_in), .data_out(data_out),
    .ps2_clock(ps2_clock), .ps2_data(ps2_data), .irq(irq)
  );

  function automatic logic [31:0] expStatus();
    logic [31:0] s;
    s = 32'(mQ.size()) << 16;
    if (mQ.size() != 0)     s = s + 32'h8000_0000;
    if (mPar)               s = s + 32'h4000_0000;
    if (mFrm)               s = s + 32'h2000_0000;
    if (mOvr)               s = s + 32'h1000_0000;
    if (mQ.size() == DEPTH) s = s + 32'h0800_0000;
    return s;
  endfunction

  function automatic logic [31:0] expData();
    if (mQ.size() == 0) return 32'h0;
    return {mQ[0], 24'h0};
  endfunction

  function automatic logic expIrq();
    return mIrqEn && (mQ.size() != 0);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called on a negedge; one-cycle strobe followed by an idle cycle.
  task automatic readReg(input logic [1:0] off, output logic [31:0] val);
    cs = 1'b1; read = 1'b1; reg_offset = off;
    #1 val = data_out;
    @(negedge clock);
    cs = 1'b0; read = 1'b0; reg_offset = 2'd0;
    @(negedge clock);
    if (off == 2'd1 && mQ.size() > 0) void'(mQ.pop_front());
  endtask

  task automatic writeReg(input logic [1:0] off, input logic [31:0] val);
    cs = 1'b1; write = 1'b1; reg_offset = off; data_in = val;
    @(negedge clock);
    cs = 1'b0; write = 1'b0; reg_offset = 2'd0; data_in = '0;
    if (off == 2'd0) begin
      if (val[30]) mPar = 0;
      if (val[29]) mFrm = 0;
      if (val[28]) mOvr = 0;
    end else if (off == 2'd2) begin
      mIrqEn = val[31];
      if (val[30]) mQ.delete();
    end
  endtask

  // One PS/2 bit: data set up while clock is high, then clock low for 4
  // cycles. Optionally a DATA read is timed so its pop lands on the same
  // system clock edge as the frame processing of this falling edge
  // (two synchroniser flops, then the edge detector's previous-value flop).
  task automatic ps2Bit(input logic b, input bit popHere, output logic [31:0] pv);
    pv = '0;
    ps2_data = b;
    cycles(4);
    ps2_clock = 1'b0;
    if (popHere) begin
      cycles(2);
      cs = 1'b1; read = 1'b1; reg_offset = 2'd1;
      #1 pv = data_out;
      cycles(1);
      cs = 1'b0; read = 1'b0; reg_offset = 2'd0;
      cycles(1);
    end else begin
      cycles(4);
    end
    ps2_clock = 1'b1;
  endtask

  task automatic sendFrame(input byte unsigned d, input bit flipPar, input bit badStop,
                           input int nBits, input int gap, input bit popAtStop,
                           output logic [31:0] pv);
    logic [10:0] b;
    logic [31:0] t;
    pv = '0;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
    b[9]  = ~(^d) ^ flipPar;
    b[10] = ~badStop;
    for (int i = 0; i < nBits; i++) begin
      if (i == 5 && gap > 0) cycles(gap);
      ps2Bit(b[i], popAtStop && (i == 10), t);
      if (i == 10) pv = t;
    end
    cycles(6);
    if (nBits == 11) begin
      if (popAtStop && mQ.size() > 0) void'(mQ.pop_front());
      if (badStop) mFrm = 1;
      if (flipPar) mPar = 1;
      if (!badStop && !flipPar) begin
        if (mQ.size() == DEPTH) mOvr = 1;
        else mQ.push_back(d);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq got=%b exp=0", irq); end
    total++;
    readReg(2'd0, v); total++;
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL reset_status got=%h exp=00000000", v); end
    readReg(2'd1, v); total++;
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL reset_data got=%h exp=00000000", v); end
    readReg(2'd2, v); total++;
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL reset_control got=%h exp=00000000", v); end
    readReg(2'd3, v); total++;
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL reset_reserved got=%h exp=00000000", v); end
  endtask

  task automatic test_single();
    logic [31:0] v, pv;
    sendFrame(8'h1C, 0, 0, 11, 0, 0, pv);
    cs = 1'b0; read = 1'b1; reg_offset = 2'd0;
    #1 total++;
    if (data_out !== 32'h0) begin bad++; $display("[TB] FAIL cs_low got=%h exp=00000000", data_out); end
    @(negedge clock); read = 1'b0;
    readReg(2'd0, v); total++;
    if (v !== 32'h8001_0000) begin bad++; $display("[TB] FAIL single_status got=%h exp=80010000", v); end
    readReg(2'd1, v); total++;
    if (v !== 32'h1C00_0000) begin bad++; $display("[TB] FAIL single_data got=%h exp=1c000000", v); end
    readReg(2'd0, v); total++;
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL single_after got=%h exp=00000000", v); end
  endtask

  task automatic test_errors();
    logic [31:0] v, pv;
    sendFrame(8'h1C, 1, 0, 11, 0, 0, pv);
    readReg(2'd0, v); total++;
    if (v !== 32'h4000_0000) begin bad++; $display("[TB] FAIL parity_status got=%h exp=40000000", v); end
    writeReg(2'd0, 32'h4000_0000);
    readReg(2'd0, v); total++;
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL parity_clear got=%h exp=00000000", v); end
    sendFrame(8'hA5, 0, 1, 11, 0, 0, pv);
    readReg(2'd0, v); total++;
    if (v !== 32'h2000_0000) begin bad++; $display("[TB] FAIL framing_status got=%h exp=20000000", v); end
    sendFrame(8'h3C, 1, 1, 11, 0, 0, pv);
    readReg(2'd0, v); total++;
    if (v !== 32'h6000_0000) begin bad++; $display("[TB] FAIL both_status got=%h exp=60000000", v); end
    writeReg(2'd0, 32'h7000_0000);
  endtask

  task automatic test_overrun();
    logic [31:0] v, pv;
    for (int i = 1; i <= 9; i++) sendFrame(byte'(i), 0, 0, 11, 0, 0, pv);
    readReg(2'd0, v); total++;
    if (v !== 32'h9808_0000) begin bad++; $display("[TB] FAIL overrun_status got=%h exp=98080000", v); end
    for (int i = 1; i <= 8; i++) begin
      readReg(2'd1, v); total++;
      if (v !== {8'(i), 24'h0}) begin bad++; $display("[TB] FAIL overrun_data%0d got=%h exp=%h", i, v, {8'(i), 24'h0}); end
    end
    writeReg(2'd0, 32'h1000_0000);
    readReg(2'd0, v); total++;
    if (v !== expStatus()) begin bad++; $display("[TB] FAIL overrun_clear got=%h exp=%h", v, expStatus()); end
  endtask

  task automatic test_timeout();
    logic [31:0] v, pv;
    sendFrame(8'h00, 0, 0, 5, 0, 0, pv);
    cycles(TMO - 60);
    readReg(2'd0, v); total++;
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL timeout_early got=%h exp=00000000", v); end
    cycles(80);
    readReg(2'd0, v); total++;
    if (v !== 32'h2000_0000) begin bad++; $display("[TB] FAIL timeout_flag got=%h exp=20000000", v); end
    writeReg(2'd0, 32'h2000_0000);
    mFrm = 0;
    sendFrame(8'h5A, 0, 0, 11, 0, 0, pv);
    readReg(2'd1, v); total++;
    if (v !== 32'h5A00_0000) begin bad++; $display("[TB] FAIL timeout_next got=%h exp=5a000000", v); end
    // A long but sub-timeout pause inside a frame must not abort it.
    sendFrame(8'hC3, 0, 0, 11, TMO - 100, 0, pv);
    readReg(2'd0, v); total++;
    if (v !== 32'h8001_0000) begin bad++; $display("[TB] FAIL slow_frame_status got=%h exp=80010000", v); end
    readReg(2'd1, v); total++;
    if (v !== 32'hC300_0000) begin bad++; $display("[TB] FAIL slow_frame_data got=%h exp=c3000000", v); end
  endtask

  task automatic test_irq_hold();
    logic [31:0] v, pv;
    writeReg(2'd2, 32'h8000_0000);
    readReg(2'd2, v); total++;
    if (v !== 32'h8000_0000) begin bad++; $display("[TB] FAIL irq_ctrl got=%h exp=80000000", v); end
    sendFrame(8'h11, 0, 0, 11, 0, 0, pv);
    sendFrame(8'h22, 0, 0, 11, 0, 0, pv);
    total++;
    if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_set got=%b exp=1", irq); end
    cs = 1'b1; read = 1'b1; reg_offset = 2'd1;
    #1 total++;
    if (data_out !== 32'h1100_0000) begin bad++; $display("[TB] FAIL hold_data got=%h exp=11000000", data_out); end
    cycles(3);
    cs = 1'b0; read = 1'b0; reg_offset = 2'd0;
    void'(mQ.pop_front());
    cycles(1);
    readReg(2'd0, v); total++;
    if (v !== 32'h8001_0000) begin bad++; $display("[TB] FAIL hold_count got=%h exp=80010000", v); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("[TB] FAIL hold_irq got=%b exp=1", irq); end
    cs = 1'b1; read = 1'b1; reg_offset = 2'd1;
    cycles(1);
    cs = 1'b0; read = 1'b0; reg_offset = 2'd0;
    void'(mQ.pop_front());
    total++;
    if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_lag got=%b exp=1", irq); end
    cycles(1);
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_fall got=%b exp=0", irq); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v, pv;
    for (int i = 0; i < DEPTH; i++) sendFrame(byte'(8'hA0 + i), 0, 0, 11, 0, 0, pv);
    readReg(2'd0, v); total++;
    if (v !== 32'h8808_0000) begin bad++; $display("[TB] FAIL full_status got=%h exp=88080000", v); end
    sendFrame(8'hB0, 0, 0, 11, 0, 1, pv);
    total++;
    if (pv !== 32'hA000_0000) begin bad++; $display("[TB] FAIL same_cycle_pop got=%h exp=a0000000", pv); end
    readReg(2'd0, v); total++;
    if (v !== 32'h8808_0000) begin bad++; $display("[TB] FAIL same_cycle_status got=%h exp=88080000", v); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("[TB] FAIL pre_flush_irq got=%b exp=1", irq); end
    writeReg(2'd2, 32'h4000_0000);
    readReg(2'd0, v); total++;
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL flush_status got=%h exp=00000000", v); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL flush_irq got=%b exp=0", irq); end
    readReg(2'd1, v); total++;
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL flush_data got=%h exp=00000000", v); end
  endtask

  task automatic test_random();
    logic [31:0] v, pv, e, clr;
    byte unsigned d;
    int kind;
    writeReg(2'd2, 32'h8000_0000);
    for (int n = 0; n < 24; n++) begin
      d = byte'($urandom);
      kind = $urandom_range(0, 7);
      sendFrame(d, kind == 0 || kind == 2, kind == 1 || kind == 2, 11, 0, 0, pv);
      e = expStatus();
      readReg(2'd0, v); total++;
      if (v !== e) begin bad++; $display("[TB] FAIL rand_status%0d got=%h exp=%h", n, v, e); end
      total++;
      if (irq !== expIrq()) begin bad++; $display("[TB] FAIL rand_irq%0d got=%b exp=%b", n, irq, expIrq()); end
      if ($urandom_range(0, 1) == 1) begin
        e = expData();
        readReg(2'd1, v); total++;
        if (v !== e) begin bad++; $display("[TB] FAIL rand_data%0d got=%h exp=%h", n, v, e); end
      end
      if ($urandom_range(0, 3) == 0) begin
        clr = $urandom;
        writeReg(2'd0, clr);
        e = expStatus();
        readReg(2'd0, v); total++;
        if (v !== e) begin bad++; $display("[TB] FAIL rand_clear%0d got=%h exp=%h", n, v, e); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v, pv;
    sendFrame(8'hFF, 0, 0, 5, 0, 0, pv);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    mQ.delete(); mPar = 0; mFrm = 0; mOvr = 0; mIrqEn = 0;
    cycles(TMO + 20);
    readReg(2'd0, v); total++;
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL midframe_status got=%h exp=00000000", v); end
    sendFrame(8'h7E, 0, 0, 11, 0, 0, pv);
    readReg(2'd1, v); total++;
    if (v !== 32'h7E00_0000) begin bad++; $display("[TB] FAIL midframe_next got=%h exp=7e000000", v); end
  endtask

  initial begin
    reset = 1'b1; cs = 0; read = 0; write = 0; reg_offset = 0; data_in = 0;
    ps2_clock = 1'b1; ps2_data = 1'b1;
    mPar = 0; mFrm = 0; mOvr = 0; mIrqEn = 0;
    cycles(3);
    reset = 1'b0;
    cycles(1);
    test_reset();
    test_single();
    test_errors();
    test_overrun();
    test_timeout();
    test_irq_hold();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Memory-mapped PS/2 keyboard receiver with a parametrised scancode FIFO, sticky error flags and an optional interrupt output.
- Contains its own input synchroniser, falling-edge detector, frame state machine and timeout.
- Replaces the single-byte scancode/ready-flag scheme behind the 0x02 I/O page, so bytes arriving faster than the CPU polls are not lost.

Parameters:
- FIFO_DEPTH, 8, scancode slots; power of two, 2..128.
- TIMEOUT_CYCLES, 12000, clock cycles with no PS/2 falling edge before a partial frame is aborted.
- SYNC_STAGES, 2, flip-flop stages on the ps2_clock and ps2_data inputs; minimum 2.

Ports:
- clock  input  1  system clock; the CPU clock domain.
- reset  input  1  synchronous, active-high.
- cs  input  1  block select, decoded from the I/O page.
- read  input  1  bus read strobe.
- write  input  1  bus write strobe.
- reg_offset  input  2  register select, driven from address[3:2]: 0 STATUS, 1 DATA, 2 CONTROL, 3 reserved.
- data_in  input  32  write data; only bits [31:24] are used.
- data_out  output  32  combinational read data for the selected register.
- ps2_clock  input  1  raw PS/2 clock line, asynchronous.
- ps2_data  input  1  raw PS/2 data line, asynchronous.
- irq  output  1  level interrupt.

Behaviour:
- Reset:
  - FIFO empty, frame FSM in IDLE, timeout counter 0.
  - All sticky flags 0, irq_enable 0, irq 0.
  - data_out is 0 whenever cs=0.
- Input path:
  - Each PS/2 line passes through SYNC_STAGES flip-flops.
  - A falling edge is synced clock 1 on the previous cycle and 0 now; it produces a one-cycle pulse.
  - ps2_data is sampled on that same cycle.
- Frame FSM, advanced only on falling-edge pulses:
  - IDLE: a sampled 0 (start bit) moves to DATA with bit counter 0. A sampled 1 is ignored.
  - DATA: shift the bit in LSB first. After the 8th bit, move to PARITY.
  - PARITY: capture the parity bit and move to STOP.
  - STOP: return to IDLE.
    - Stop bit 0: set framing_err, drop the byte.
    - Odd-parity check fails (data plus parity bit has an even number of ones): set parity_err, drop the byte.
    - Both checks fail: set both flags.
    - Otherwise push the byte.
- Timeout:
  - The counter runs in every state except IDLE and clears on each falling-edge pulse.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, set framing_err, discard the partial byte.
- FIFO:
  - Push into a full FIFO drops the byte and sets overrun. Existing contents are untouched.
  - Pop is generated on the rising edge of (cs & read & reg_offset==1), so a multi-cycle read strobe pops exactly once.
  - Pop on empty does nothing.
  - Push and pop in the same cycle: the pop is applied first, so the push always succeeds and count is unchanged.
- STATUS register, read:
  - [31] not_empty.
  - [30] parity_err.
  - [29] framing_err.
  - [28] overrun.
  - [27] full.
  - [23:16] count, zero-extended.
  - All other bits 0.
- STATUS register, write: write-1-to-clear, [30:28] only. If a clear and a set of the same flag happen in one cycle, the set wins.
- DATA register:
  - Read: {head byte, 24'h0}. Returns 0 when the FIFO is empty.
  - Write: ignored.
- CONTROL register:
  - Read: {irq_enable, 31'b0}.
  - Write: [31] sets irq_enable. [30]=1 flushes: FIFO emptied, FSM forced to IDLE, timeout counter cleared. Sticky flags are untouched.
  - A push in the same cycle as a flush is discarded.
- irq is registered: irq <= irq_enable & not_empty, one cycle after the causing state change.
- Reserved offset: reads 0, writes ignored.
- Reset mid-frame: partial frame discarded, no flag set.

Test Plan:
- Send frame 0x1C (start 0, bits LSB first, parity 0, stop 1) -> STATUS reads 0x8001_0000; DATA reads 0x1C00_0000; next STATUS reads 0x0000_0000.
- Send 9 valid bytes 0x01..0x09 with FIFO_DEPTH=8, no reads -> STATUS reads 0x9808_0000 (not_empty, overrun, full, count 8). Eight DATA reads return 0x01..0x08 in order.
- Send 0x1C with the parity bit flipped -> not_empty stays 0, STATUS[30]=1. Write 0x4000_0000 to STATUS -> reads 0x0000_0000.
- Send 5 bits then stop toggling ps2_clock for TIMEOUT_CYCLES cycles -> framing_err=1, FSM in IDLE. A following valid 0x5A is received correctly.
- Set irq_enable, hold DATA read asserted for 3 cycles with 2 bytes queued -> exactly one pop, count 2->1, irq stays 1. Second pop -> irq falls one cycle later.
- Time a pop on the same cycle as the final push with the FIFO full -> count stays 8, no overrun. Then write 0x4000_0000 to CONTROL -> count 0 and irq 0 on the following cycle.
